// File: rtl/exe_fwd_ctrl_pkg.sv
// Shared types for the EXE-stage forwarding/hazard controller: select codes,
// pipeline shadow record and the dependency-match helper.
package exe_fwd_ctrl_pkg;

    localparam int REG_ADDR_LEN    = 5;
    localparam int FORWARD_SEL_LEN = 2;
    localparam int CNT_LEN         = 16;

    typedef enum logic [FORWARD_SEL_LEN-1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_LEN-1:0] dest;
        logic                    wb_en;
        logic                    mem_rd;
    } pipe_shadow_t;

    localparam pipe_shadow_t SHADOW_BUBBLE = '0;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic dep_match(input logic [REG_ADDR_LEN-1:0] s,
                                       input pipe_shadow_t          e);
        return e.valid & e.wb_en & (e.dest == s) & (s != '0);
    endfunction

endpackage

// File: rtl/exe_fwd_ctrl_fwd_select.sv
// Combinational operand-source picker: the newest in-flight writer of i_src wins.
module fwd_select
    import exe_fwd_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] i_src,
    input  logic                    i_used,
    input  pipe_shadow_t            i_ex,
    input  pipe_shadow_t            i_mem,
    output fwd_sel_t                o_sel
);

    logic w_hit_ex;
    logic w_hit_mem;

    assign w_hit_ex  = dep_match(i_src, i_ex) & ~i_ex.mem_rd;
    assign w_hit_mem = dep_match(i_src, i_mem);

    // A load still in EX is handled by the stall, so it only matters once it reaches MEM.
    always_comb begin
        o_sel = FWD_NONE;
        if (i_used) begin
            if (w_hit_ex) begin
                o_sel = FWD_MEM;
            end else if (w_hit_mem) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/exe_fwd_ctrl.sv
// EXE-stage forwarding/hazard controller: shadows EX/MEM destinations, registers
// operand-select codes aligned with the instruction in EX, and stalls on load-use.
module exe_fwd_ctrl #(
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         freeze,
    input  logic                                         flush,
    input  logic                                         id_valid,
    input  logic [REG_ADDR_LEN-1:0]                      id_src1,
    input  logic [REG_ADDR_LEN-1:0]                      id_src2,
    input  logic                                         id_use_imm,
    input  logic                                         id_is_store,
    input  logic [REG_ADDR_LEN-1:0]                      id_dest,
    input  logic                                         id_wb_en,
    input  logic                                         id_mem_rd,
    output logic [exe_fwd_ctrl_pkg::FORWARD_SEL_LEN-1:0] val1_sel,
    output logic [exe_fwd_ctrl_pkg::FORWARD_SEL_LEN-1:0] val2_sel,
    output logic [exe_fwd_ctrl_pkg::FORWARD_SEL_LEN-1:0] ST_val_sel,
    output logic                                         stall,
    output logic [CNT_LEN-1:0]                           stall_count
);

    // The WB-stage copy would retire before any consumer could select it,
    // so only the EX and MEM shadows are kept.
    exe_fwd_ctrl_pkg::pipe_shadow_t r_ex;
    exe_fwd_ctrl_pkg::pipe_shadow_t r_mem;
    exe_fwd_ctrl_pkg::pipe_shadow_t w_id_shadow;

    exe_fwd_ctrl_pkg::fwd_sel_t r_val1_sel;
    exe_fwd_ctrl_pkg::fwd_sel_t r_val2_sel;
    exe_fwd_ctrl_pkg::fwd_sel_t r_st_sel;
    exe_fwd_ctrl_pkg::fwd_sel_t w_val1_sel;
    exe_fwd_ctrl_pkg::fwd_sel_t w_val2_sel;
    exe_fwd_ctrl_pkg::fwd_sel_t w_st_sel;

    logic [CNT_LEN-1:0] r_stall_count;

    logic w_use_src2;
    logic w_ld_hit1;
    logic w_ld_hit2;
    logic w_stall;
    logic w_load_ex;

    assign w_use_src2 = ~id_use_imm | id_is_store;
    assign w_ld_hit1  = exe_fwd_ctrl_pkg::dep_match(id_src1, r_ex) & r_ex.mem_rd;
    assign w_ld_hit2  = exe_fwd_ctrl_pkg::dep_match(id_src2, r_ex) & r_ex.mem_rd;

    // flush outranks the hazard: the consumer is being killed anyway.
    assign w_stall   = ~rst & id_valid & ~flush & (w_ld_hit1 | (w_use_src2 & w_ld_hit2));
    assign w_load_ex = id_valid & ~w_stall & ~flush;

    assign w_id_shadow = '{valid:  1'b1,
                           dest:   id_dest,
                           wb_en:  id_wb_en,
                           mem_rd: id_mem_rd};

    fwd_select u_sel_val1 (
        .i_src  (id_src1),
        .i_used (1'b1),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_sel  (w_val1_sel)
    );

    fwd_select u_sel_val2 (
        .i_src  (id_src2),
        .i_used (~id_use_imm),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_sel  (w_val2_sel)
    );

    fwd_select u_sel_st (
        .i_src  (id_src2),
        .i_used (id_is_store),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_sel  (w_st_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex          <= exe_fwd_ctrl_pkg::SHADOW_BUBBLE;
            r_mem         <= exe_fwd_ctrl_pkg::SHADOW_BUBBLE;
            r_val1_sel    <= exe_fwd_ctrl_pkg::FWD_NONE;
            r_val2_sel    <= exe_fwd_ctrl_pkg::FWD_NONE;
            r_st_sel      <= exe_fwd_ctrl_pkg::FWD_NONE;
            r_stall_count <= '0;
        end else if (!freeze) begin
            r_mem <= r_ex;
            if (w_load_ex) begin
                r_ex       <= w_id_shadow;
                r_val1_sel <= w_val1_sel;
                r_val2_sel <= w_val2_sel;
                r_st_sel   <= w_st_sel;
            end else begin
                r_ex       <= exe_fwd_ctrl_pkg::SHADOW_BUBBLE;
                r_val1_sel <= exe_fwd_ctrl_pkg::FWD_NONE;
                r_val2_sel <= exe_fwd_ctrl_pkg::FWD_NONE;
                r_st_sel   <= exe_fwd_ctrl_pkg::FWD_NONE;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign val1_sel    = r_val1_sel;
    assign val2_sel    = r_val2_sel;
    assign ST_val_sel  = r_st_sel;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule
